neuron_lut_loader: RTL and testbench

//   Runtime-programmable truth-table neuron: the write side for the fixed-ROM LUT neurons of the

---
 rtl/neuron_lut_if.sv | 24 ++
 rtl/neuron_lut_loader.sv | 112 +++++++++++
 tb/tb_neuron_lut_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/neuron_lut_if.sv
// Packed truth-table stream: valid/ready beats of EPB entries.
// The last beat of a table carries s_last.
interface neuron_lut_if #(
  parameter int WORD_BITS = 32
);
  logic                 s_valid;
  logic                 s_ready;
  logic [WORD_BITS-1:0] s_data;
  logic                 s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/neuron_lut_loader.sv
// Runtime-loadable truth-table neuron: a stream fills a 2^IN_BITS table,
// and M0 -> M1 lookups are served once a complete, well-framed load lands.
module neuron_lut_loader #(
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 2,
  parameter int WORD_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  neuron_lut_if.slave         s,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic [IN_BITS-1:0]  M0,
  output logic [OUT_BITS-1:0] M1,
  output logic                M1_valid
);

  localparam int EPB    = WORD_BITS / OUT_BITS;
  localparam int DEPTH  = 1 << IN_BITS;
  localparam int NBEATS = DEPTH / EPB;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int EPB_W  = $clog2(EPB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]    beat_cnt;
  logic                tbl_ok;
  logic [OUT_BITS-1:0] tbl [DEPTH];

  logic                fire;
  logic                last_beat;
  logic                complete;
  logic                frame_err;
  logic                enter_load;
  logic [IN_BITS-1:0]  base;

  assign s.s_ready  = (state_q == LOAD);
  assign busy       = (state_q == LOAD);
  assign fire       = s.s_valid & s.s_ready;
  assign last_beat  = (beat_cnt == CNT_W'(NBEATS - 1));
  assign complete   = fire & last_beat & s.s_last;
  assign frame_err  = fire & (last_beat ^ s.s_last);
  assign enter_load = load_start & (state_q != LOAD);
  assign base       = IN_BITS'(beat_cnt) << EPB_W;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (load_start) state_d = LOAD;
      LOAD: begin
        if (complete)       state_d = IDLE;
        else if (frame_err) state_d = ERR;
      end
      ERR:  if (load_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_cnt <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      tbl_ok   <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= complete;
      unique case (1'b1)
        enter_load: begin
          beat_cnt <= '0;
          err      <= 1'b0;
          tbl_ok   <= 1'b0;
        end
        fire: begin
          beat_cnt <= beat_cnt + 1'b1;
          if (frame_err) err    <= 1'b1;
          if (complete)  tbl_ok <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Table RAM has no reset; tbl_ok alone gates what lookups may expose.
  always_ff @(posedge clk) begin
    if (fire) begin
      for (int k = 0; k < EPB; k++) begin
        tbl[base + IN_BITS'(k)] <= s.s_data[k*OUT_BITS +: OUT_BITS];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      M1       <= '0;
      M1_valid <= 1'b0;
    end else begin
      M1       <= tbl_ok ? tbl[M0] : '0;
      M1_valid <= tbl_ok;
    end
  end

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Bench for neuron_lut_loader: random table loads against an array model,
// with framing errors, stream gaps and a mid-load reset.
module tb_neuron_lut_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic [7:0] M0;
  logic [1:0] M1;
  logic       busy, done, err, M1_valid;

  neuron_lut_if #(.WORD_BITS(32)) s_if();

  neuron_lut_loader #(
    .IN_BITS  (8),
    .OUT_BITS (2),
    .WORD_BITS(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .s         (s_if.slave),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .M0        (M0),
    .M1        (M1),
    .M1_valid  (M1_valid)
  );

  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int base_cnt;

  logic [1:0]  ref_tbl [256];
  bit          ref_ok;
  bit          ref_err;
  logic [31:0] words [16];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic lookup(logic [7:0] a);
    M0 = a;
    tick();
    chk("M1", {30'd0, M1}, ref_ok ? {30'd0, ref_tbl[a]} : 32'd0);
    chk("M1_valid", {31'd0, M1_valid}, {31'd0, ref_ok});
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    ref_ok  = 1'b0;
    ref_err = 1'b0;
    chk("busy_on_start", {31'd0, busy}, 32'd1);
    chk("ready_on_start", {31'd0, s_if.s_ready}, 32'd1);
    chk("err_cleared", {31'd0, err}, {31'd0, ref_err});
  endtask

  task automatic send_beat(logic [31:0] d, bit last, output bit acc);
    int n = 0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    s_if.s_last  = last;
    while (s_if.s_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    acc = (s_if.s_ready === 1'b1);
    if (!acc) chk("ready_timeout", {31'd0, s_if.s_ready}, 32'd1);
    tick();
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    s_if.s_data  = $urandom;
  endtask

  // Sends beats 0..nbeats-1; s_last goes on beat last_at (-1: never).
  task automatic load_table(int nbeats, int last_at, int gap_after,
                            int gap_len, bit rgaps);
    bit acc;
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_after + 1) tick(gap_len);
      else if (rgaps) tick($urandom_range(0, 2));
      send_beat(words[b], b == last_at, acc);
      if (!acc) return;
      for (int k = 0; k < 16; k++) ref_tbl[b*16 + k] = words[b][2*k +: 2];
      if ((b == 15) != (b == last_at)) begin
        ref_err = 1'b1;
        chk("err_set", {31'd0, err}, {31'd0, ref_err});
        chk("no_done_on_err", {31'd0, done}, 32'd0);
        chk("ready_drop", {31'd0, s_if.s_ready}, 32'd0);
        chk("busy_err", {31'd0, busy}, 32'd0);
        return;
      end
      if (b == 15) begin
        ref_ok = 1'b1;
        chk("done", {31'd0, done}, 32'd1);
        chk("err_ok", {31'd0, err}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("M1_valid_old", {31'd0, M1_valid}, 32'd0);
      end else begin
        chk("busy_mid", {31'd0, busy}, 32'd1);
        chk("done_mid", {31'd0, done}, 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    load_start   = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    s_if.s_last  = 1'b0;
    M0           = 8'hFF;
    ref_ok       = 1'b0;
    ref_err      = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();
    chk("rst_M1", {30'd0, M1}, 32'd0);
    chk("rst_M1_valid", {31'd0, M1_valid}, 32'd0);
    chk("rst_ready", {31'd0, s_if.s_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    for (int b = 0; b < 16; b++) words[b] = 32'hE4E4_E4E4;
    start_load();
    load_table(16, 15, -10, 0, 1'b0);
    lookup(8'h05);
    chk("lut_05_const", {30'd0, M1}, 32'd1);
    repeat (16) lookup(8'($urandom_range(0, 255)));

    for (int b = 0; b < 16; b++) words[b] = $urandom;
    base_cnt = done_cnt;
    start_load();
    lookup(8'h05);
    load_table(16, 15, 7, 3, 1'b0);
    tick();
    chk("done_once", done_cnt - base_cnt, 32'd1);
    repeat (16) lookup(8'($urandom_range(0, 255)));

    for (int b = 0; b < 16; b++) words[b] = $urandom;
    start_load();
    load_table(16, 9, -10, 0, 1'b1);
    lookup(8'h00);
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk("ready_in_err", {31'd0, s_if.s_ready}, 32'd0);

    base_cnt = done_cnt;
    start_load();
    load_table(16, -1, -10, 0, 1'b1);
    tick();
    chk("no_done_no_last", done_cnt - base_cnt, 32'd0);
    lookup(8'h80);

    for (int b = 0; b < 16; b++) words[b] = $urandom;
    start_load();
    load_table(16, 15, -10, 0, 1'b1);
    repeat (12) lookup(8'($urandom_range(0, 255)));

    for (int b = 0; b < 16; b++) words[b] = $urandom;
    start_load();
    load_table(6, -1, -10, 0, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_ready", {31'd0, s_if.s_ready}, 32'd0);
    ref_ok  = 1'b0;
    ref_err = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_valid", {31'd0, M1_valid}, 32'd0);
    lookup(8'h03);

    for (int b = 0; b < 16; b++) words[b] = 32'hFFFF_FFFF;
    start_load();
    load_table(16, 15, -10, 0, 1'b1);
    lookup(8'd0);
    chk("ones_0", {30'd0, M1}, 32'd3);
    lookup(8'd128);
    chk("ones_128", {30'd0, M1}, 32'd3);
    lookup(8'd255);
    chk("ones_255", {30'd0, M1}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
